serial_sub16: RTL and testbench

Bit-serial 16-bit subtractor: the inverse-direction counterpart of the combinational `ripple16` adder. It latches two operands and a borrow-in on a start pulse. It then computes D = A − B − Bin one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop, and reports completion with a one-cycle done pulse. It is the datapath block for the lab's sequential arithmetic unit and trades 16 cycles of latency for one subtractor cell instead of sixteen.

---
 rtl/serial_sub16.sv | 116 +++++++++++
 tb/tb_serial_sub16.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/serial_sub16.sv
// serial_sub16: bit-serial A - B - Bin, one full-subtractor cell, LSB first.
// Operands load on start; D/Bout/ovf are valid with the one-cycle done pulse.
`timescale 1ns/1ps
module serial_sub16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             br;
    logic             as_s;
    logic             bs_s;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             last;
    logic             d_bit;
    logic             br_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        d_bit     = a[0] ^ b[0] ^ br;
        br_nxt    = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & br);
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    last      = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a    <= '0;
            b    <= '0;
            br   <= 1'b0;
            as_s <= 1'b0;
            bs_s <= 1'b0;
            cnt  <= '0;
            D    <= '0;
            Bout <= 1'b0;
            ovf  <= 1'b0;
        end else if (accept) begin
            a    <= A;
            b    <= B;
            br   <= Bin;
            as_s <= A[WIDTH-1];
            bs_s <= B[WIDTH-1];
            cnt  <= '0;
        end else if (state == S_RUN) begin
            a   <= a >> 1;
            b   <= b >> 1;
            br  <= br_nxt;
            D   <= {d_bit, D[WIDTH-1:1]};
            cnt <= cnt + CW'(1);
            if (last) begin
                // d_bit is the result sign bit on the final edge
                Bout <= br_nxt;
                ovf  <= (as_s != bs_s) && (d_bit != as_s);
            end
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_sub16.sv
// tb_serial_sub16: directed vectors, expected results queued by stimulus,
// popped and compared by a monitor on every done pulse.
`timescale 1ns/1ps
module tb_serial_sub16;

    typedef struct packed {
        logic [15:0] d;
        logic        bo;
        logic        ov;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        Bin;
    logic [15:0] D;
    logic        Bout;
    logic        ovf;
    logic        busy;
    logic        done;

    exp_t q[$];
    int   tests;
    int   fails;
    int   done_cnt;

    serial_sub16 dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .A    (A),
        .B    (B),
        .Bin  (Bin),
        .D    (D),
        .Bout (Bout),
        .ovf  (ovf),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // monitor: compare each completed result against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            done_cnt++;
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got D=%h with empty queue", D);
            end else begin
                e = q.pop_front();
                chk("D", {16'h0, D}, {16'h0, e.d});
                chk("Bout", {31'h0, Bout}, {31'h0, e.bo});
                chk("ovf", {31'h0, ovf}, {31'h0, e.ov});
            end
        end
    end

    // called #1 after a posedge; returns #1 after the accepting edge
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic bin, input bit push,
                         input logic [15:0] ed, input logic ebo,
                         input logic eov);
        A     = a;
        B     = b;
        Bin   = bin;
        start = 1'b1;
        if (push) q.push_back('{d: ed, bo: ebo, ov: eov});
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_after_accept", {31'h0, busy}, 32'h1);
    endtask

    task automatic wait_done(output int n);
        bit busy_ok;
        n = 0;
        busy_ok = 1'b1;
        do begin
            @(posedge clk);
            #1 n++;
            if (!done && !busy) busy_ok = 1'b0;
        end while (!done && n < 40);
        chk("busy_during_run", {31'h0, busy_ok}, 32'h1);
    endtask

    initial begin
        int n;
        int dc;
        tests    = 0;
        fails    = 0;
        done_cnt = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        A        = '0;
        B        = '0;
        Bin      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1 chk("idle", {12'h0, D, Bout, ovf, busy, done}, 32'h0);
        end

        issue(16'hF04E, 16'hBCA9, 1'b0, 1'b1, 16'h33A5, 1'b0, 1'b0);
        wait_done(n);
        chk("latency", n, 16);
        @(posedge clk);
        #1 chk("done_width", {31'h0, done}, 32'h0);
        repeat (3) @(posedge clk);
        #1 chk("hold", {14'h0, D, Bout, ovf}, {14'h0, 16'h33A5, 2'b00});

        issue(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        wait_done(n);
        chk("lat_borrow1", n, 16);
        @(posedge clk);
        #1;
        issue(16'h1234, 16'h1234, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        wait_done(n);
        @(posedge clk);
        #1;
        issue(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1);
        wait_done(n);
        @(posedge clk);
        #1;

        issue(16'h5555, 16'h1111, 1'b0, 1'b1, 16'h4444, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        A     = 16'hFFFF;
        B     = 16'h0000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(n);
        chk("lat_ignore_start", n, 10);
        issue(16'hA457, 16'h75A5, 1'b1, 1'b1, 16'h2EB1, 1'b0, 1'b1);
        wait_done(n);
        chk("lat_back_to_back", n + 1, 17);
        @(posedge clk);
        #1;

        issue(16'h1234, 16'h0001, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("rst_async", {12'h0, D, Bout, ovf, busy, done}, 32'h0);
        dc = done_cnt;
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1 chk("no_done_after_rst", done_cnt, dc);
        issue(16'h00FF, 16'h0F0F, 1'b0, 1'b1, 16'hF1F0, 1'b1, 1'b0);
        wait_done(n);
        chk("lat_after_rst", n, 16);
        repeat (3) @(posedge clk);
        #1 chk("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
